seg_scan_ctrl: RTL

//   Time-multiplexed scan controller for an 8-digit common-bus 7-segment display.
//   - Holds one 4-bit hex value per digit, written by a simple write port.
//   - Rotates the 3-bit digit select through all digits.
//   - Drives the decoded segment pattern for the selected digit.
//   - Inserts a blanking gap at each digit change to suppress ghosting.

---
 rtl/seg_scan_pkg.sv | 22 ++
 rtl/hex7seg_dec.sv | 11 +
 rtl/seg_scan_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Holds the FSM state type, the hex-to-segment table and the dark pattern.
package seg_scan_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam logic [7:0] SEG_DARK = 8'h00;

  // Index 0 is the least significant element: entry n is the pattern for hex digit n.
  localparam logic [15:0][7:0] SEG_LUT = {
    8'h71, 8'h79, 8'h5e, 8'h39, 8'h7c, 8'h77, 8'h6f, 8'h7f,
    8'h07, 8'h7d, 8'h6d, 8'h66, 8'h4f, 8'h5b, 8'h06, 8'h3f
  };

  function automatic logic [7:0] seg_decode(input logic [3:0] hex);
    return SEG_LUT[hex];
  endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex digit to 7-segment pattern decoder (bit0=a .. bit6=g, bit7=dp).
module hex7seg_dec
  import seg_scan_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [7:0] seg_o
);

  assign seg_o = seg_decode(hex_i);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit common-bus 7-segment display with blanking gaps.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zeros (digit 0 always lit).
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DWELL_CYC  = 50000,
  parameter int BLANK_CYC  = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  output logic [7:0] seg,
  output logic [2:0] sel,
  output logic       frame
);

  localparam int CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
  localparam logic [2:0]       PTR_LAST   = 3'(NUM_DIGITS - 1);
  localparam logic [3:0]       NUM_DIG4   = 4'(NUM_DIGITS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [7:0]       seg_q, seg_d;
  logic             frame_q, frame_d;
  logic [3:0]       digit_q [8];

  logic [2:0] ptr_next;
  logic [7:0] dec_seg;
  logic [7:0] show_pat;
  logic       wr_valid;

  assign ptr_next = (ptr_q == PTR_LAST) ? 3'd0 : ptr_q + 3'd1;
  assign wr_valid = wr_en && ({1'b0, wr_addr} < NUM_DIG4);

  // Decoding the registered value gives "old value wins" when a write lands on SHOW entry.
  hex7seg_dec u_dec (
    .hex_i (digit_q[ptr_q]),
    .seg_o (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [7:0] lz_blank;

  always_comb begin : lz_scan
    logic nz_above;
    nz_above = 1'b0;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_blank[i] = (i != 0) && !nz_above && (digit_q[i] == 4'h0);
      nz_above    = nz_above | (digit_q[i] != 4'h0);
    end
  end

  assign show_pat = lz_blank[ptr_q] ? SEG_DARK : dec_seg;
`else
  assign show_pat = dec_seg;
`endif

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    seg_d   = seg_q;
    frame_d = 1'b0;

    if (state_q == BLANK) begin
      seg_d = SEG_DARK;
      if (!en) begin
        cnt_d = BLANK_LAST;
      end else if (cnt_q >= BLANK_LAST) begin
        state_d = SHOW;
        cnt_d   = '0;
        seg_d   = show_pat;
        frame_d = (ptr_q == 3'd0);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      // Dropping en aborts the visit without advancing to the next digit.
      if (!en) begin
        state_d = BLANK;
        cnt_d   = '0;
        seg_d   = SEG_DARK;
      end else if (cnt_q >= DWELL_LAST) begin
        state_d = BLANK;
        cnt_d   = '0;
        seg_d   = SEG_DARK;
        ptr_d   = ptr_next;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      ptr_q   <= '0;
      seg_q   <= SEG_DARK;
      frame_q <= 1'b0;
      // NOTE: the digit file is reset on purpose; a reset must return the display to all zeros.
      for (int i = 0; i < 8; i++) begin
        digit_q[i] <= 4'h0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
      if (wr_valid) begin
        digit_q[wr_addr] <= wr_data;
      end
    end
  end

  // sel is the digit pointer itself, so it only moves on the SHOW->BLANK edge.
  assign seg   = seg_q;
  assign sel   = ptr_q;
  assign frame = frame_q;

endmodule
